// File: rtl/led_seq_pkg.sv
// Shared CSR definitions for the LED blink-pattern sequencer: register
// offsets, CTRL bit positions and a CTRL read-back packer.
package led_seq_pkg;

    localparam logic [4:0] CSR_CTRL_OFS    = 5'd0;
    localparam logic [4:0] CSR_PATTERN_OFS = 5'd1;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_ONESHOT_BIT = 1;
    localparam int CTRL_DIV_LSB     = 2;
    localparam int CTRL_DIV_MSB     = 4;
    localparam int CTRL_BUSY_BIT    = 7;

    localparam logic [2:0] LAST_SLOT = 3'd7;

    // Reserved bits [6:5] always read back as zero.
    function automatic logic [7:0] ctrl_pack(input logic busy, input logic [2:0] div,
                                             input logic oneshot, input logic en);
        return {busy, 2'b00, div, oneshot, en};
    endfunction

endpackage

// File: rtl/led_seq.sv
// CSR-mapped LED blink-pattern sequencer: shifts an 8-bit pattern to an
// active-low LED, one slot per DIV+1 ce_8hz ticks, continuous or one-shot.
module led_seq
    import led_seq_pkg::*;
#(
    parameter logic [4:0] BASE_ADDR   = 5'h1d,
    parameter logic [7:0] RST_CTRL    = 8'h01,
    parameter logic [7:0] RST_PATTERN = 8'h0f
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce_8hz,
    input  logic [4:0] csr_a,
    input  logic [7:0] csr_di,
    input  logic       csr_we,
    output logic [7:0] csr_do,
    input  logic       pwr_enable,
    output logic       led_n
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [4:0] CTRL_ADDR    = BASE_ADDR + CSR_CTRL_OFS;
    localparam logic [4:0] PATTERN_ADDR = BASE_ADDR + CSR_PATTERN_OFS;

    state_t     state_q, state_d;
    logic       en_q, en_d;
    logic       oneshot_q, oneshot_d;
    logic [2:0] div_q, div_d;
    logic [7:0] pattern_q, pattern_d;
    logic [7:0] shadow_q, shadow_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] tick_q, tick_d;
    logic       start_pend_q;
    logic       led_n_d;

    logic ctrl_wr, pattern_wr, start, stop, tick_hit, boundary;

    always_comb begin
        ctrl_wr    = csr_we && (csr_a == CTRL_ADDR);
        pattern_wr = csr_we && (csr_a == PATTERN_ADDR);
        pattern_d  = pattern_wr ? csr_di : pattern_q;

        // A restart comes from a CTRL write with EN=1, or from the first cycle
        // after reset when the reset value of CTRL has EN set.
        start = ctrl_wr ? csr_di[CTRL_EN_BIT] : (start_pend_q && en_q);
        stop  = ctrl_wr && !csr_di[CTRL_EN_BIT];

        // >= keeps the sequencer sane if DIV is lowered beneath a running tick.
        tick_hit = (tick_q >= div_q);
        boundary = (idx_q == LAST_SLOT) && tick_hit;

        state_d   = state_q;
        en_d      = en_q;
        oneshot_d = oneshot_q;
        div_d     = div_q;
        shadow_d  = shadow_q;
        idx_d     = idx_q;
        tick_d    = tick_q;

        if (ctrl_wr) begin
            en_d      = csr_di[CTRL_EN_BIT];
            oneshot_d = csr_di[CTRL_ONESHOT_BIT];
            div_d     = csr_di[CTRL_DIV_MSB:CTRL_DIV_LSB];
        end

        if (start) begin
            state_d  = RUN;
            idx_d    = 3'd0;
            tick_d   = 3'd0;
            shadow_d = pattern_d;
        end else if (stop) begin
            state_d = IDLE;
            idx_d   = 3'd0;
            tick_d  = 3'd0;
        end else if (state_q == RUN && ce_8hz) begin
            if (tick_hit) begin
                tick_d = 3'd0;
                idx_d  = idx_q + 3'd1;
                if (boundary) begin
                    shadow_d = pattern_d;
                    if (oneshot_q) begin
                        en_d    = 1'b0;
                        state_d = IDLE;
                        idx_d   = 3'd0;
                    end
                end
            end else begin
                tick_d = tick_q + 3'd1;
            end
        end

        led_n_d = ~((state_q == RUN) && shadow_q[idx_q] && pwr_enable);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            en_q         <= RST_CTRL[CTRL_EN_BIT];
            oneshot_q    <= RST_CTRL[CTRL_ONESHOT_BIT];
            div_q        <= RST_CTRL[CTRL_DIV_MSB:CTRL_DIV_LSB];
            pattern_q    <= RST_PATTERN;
            shadow_q     <= RST_PATTERN;
            idx_q        <= 3'd0;
            tick_q       <= 3'd0;
            start_pend_q <= 1'b1;
            led_n        <= 1'b1;
        end else begin
            state_q      <= state_d;
            en_q         <= en_d;
            oneshot_q    <= oneshot_d;
            div_q        <= div_d;
            pattern_q    <= pattern_d;
            shadow_q     <= shadow_d;
            idx_q        <= idx_d;
            tick_q       <= tick_d;
            start_pend_q <= 1'b0;
            led_n        <= led_n_d;
        end
    end

    // Read data is ORed into a shared bus, so unaddressed reads return zero.
    always_comb begin
        csr_do = 8'h00;
        if (csr_a == CTRL_ADDR)
            csr_do = ctrl_pack(state_q == RUN, div_q, oneshot_q, en_q);
        else if (csr_a == PATTERN_ADDR)
            csr_do = pattern_q;
    end

endmodule
